clk_wiz_0: RTL and testbench

CLK_WIZ_0 -- requirements
Module: clk_wiz_0

---
 rtl/clk_wiz_0.sv | 97 +++++++++
 tb/tb_clk_wiz_0.sv | 101 ++++++++++
 2 files changed

// File: rtl/clk_wiz_0.sv
// rtl/clk_wiz_0.sv - lock-gated integer clock divider producing wb_clk and clk_100ns
module clk_wiz_0 #(
    parameter int WB_DIV      = 18,
    parameter int SLOW_DIV    = 10,
    parameter int LOCK_CYCLES = 64
) (
    input  logic clk_in1,
    input  logic reset,
    output logic wb_clk,
    output logic clk_100ns,
    output logic locked
);

    // Out-of-range parameters stop elaboration.
    if (WB_DIV < 2 || WB_DIV > 256) begin : g_bad_wb_div
        $error("clk_wiz_0: WB_DIV out of range 2..256");
    end
    if (SLOW_DIV < 2 || SLOW_DIV > 256) begin : g_bad_slow_div
        $error("clk_wiz_0: SLOW_DIV out of range 2..256");
    end
    if (LOCK_CYCLES < 4 || LOCK_CYCLES > 65535) begin : g_bad_lock
        $error("clk_wiz_0: LOCK_CYCLES out of range 4..65535");
    end

    // Two synchronizer edges precede the first counted edge, so the counter
    // value seen on the locking edge is LOCK_CYCLES-3.
    localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 3);
    localparam logic [7:0]  WB_LAST   = 8'(WB_DIV - 1);
    localparam logic [7:0]  WB_HIGH   = 8'(WB_DIV / 2);
    localparam logic [7:0]  SL_LAST   = 8'(SLOW_DIV - 1);
    localparam logic [7:0]  SL_HIGH   = 8'(SLOW_DIV / 2);

    logic [1:0]  r_sync;
    logic [15:0] r_lock_cnt;
    logic        r_locked;
    logic [7:0]  r_wb_cnt;
    logic [7:0]  r_sl_cnt;
    logic        r_wb_clk;
    logic        r_sl_clk;
    logic        w_rst_ok;

    assign w_rst_ok  = r_sync[1];
    assign wb_clk    = r_wb_clk;
    assign clk_100ns = r_sl_clk;
    assign locked    = r_locked;

    // Reset release synchronizer; assertion clears it asynchronously.
    always_ff @(posedge clk_in1 or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    // Lock counter: counts once released, freezes when locked is set.
    always_ff @(posedge clk_in1 or negedge reset) begin
        if (!reset) begin
            r_lock_cnt <= 16'd0;
            r_locked   <= 1'b0;
        end else if (w_rst_ok && !r_locked) begin
            r_lock_cnt <= r_lock_cnt + 16'd1;
            if (r_lock_cnt == LOCK_LAST) begin
                r_locked <= 1'b1;
            end
        end
    end

    // wb_clk divider: counter holds the phase of the cycle being entered.
    always_ff @(posedge clk_in1 or negedge reset) begin
        if (!reset) begin
            r_wb_cnt <= 8'd0;
            r_wb_clk <= 1'b0;
        end else if (!r_locked) begin
            r_wb_cnt <= 8'd0;
            r_wb_clk <= 1'b0;
        end else begin
            r_wb_clk <= (r_wb_cnt < WB_HIGH);
            r_wb_cnt <= (r_wb_cnt == WB_LAST) ? 8'd0 : r_wb_cnt + 8'd1;
        end
    end

    // clk_100ns divider: same scheme, so both outputs rise on the same edge.
    always_ff @(posedge clk_in1 or negedge reset) begin
        if (!reset) begin
            r_sl_cnt <= 8'd0;
            r_sl_clk <= 1'b0;
        end else if (!r_locked) begin
            r_sl_cnt <= 8'd0;
            r_sl_clk <= 1'b0;
        end else begin
            r_sl_clk <= (r_sl_cnt < SL_HIGH);
            r_sl_cnt <= (r_sl_cnt == SL_LAST) ? 8'd0 : r_sl_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_clk_wiz_0.sv
// tb/tb_clk_wiz_0.sv - scoreboard bench for clk_wiz_0 at default and small-divider settings
module tb_clk_wiz_0;

    logic clk_in1;
    logic reset;
    logic a_wb, a_sl, a_lk;
    logic b_wb, b_sl, b_lk;

    int total = 0;
    int bad   = 0;
    logic [5:0] sb[$];

    clk_wiz_0 u_a (
        .clk_in1  (clk_in1),
        .reset    (reset),
        .wb_clk   (a_wb),
        .clk_100ns(a_sl),
        .locked   (a_lk)
    );

    clk_wiz_0 #(.WB_DIV(5), .SLOW_DIV(3), .LOCK_CYCLES(4)) u_b (
        .clk_in1  (clk_in1),
        .reset    (reset),
        .wb_clk   (b_wb),
        .clk_100ns(b_sl),
        .locked   (b_lk)
    );

    initial clk_in1 = 1'b0;
    always #5 clk_in1 = ~clk_in1;

    // Expected {locked, wb_clk, clk_100ns} after the k-th rising edge since release.
    function automatic logic [2:0] model(int k, int l, int wd, int sd);
        logic lk, w, s;
        int p;
        lk = (k >= l);
        w  = 1'b0;
        s  = 1'b0;
        if (k > l) begin
            p = (k - l - 1) % wd;
            w = (p < wd / 2);
            p = (k - l - 1) % sd;
            s = (p < sd / 2);
        end
        return {lk, w, s};
    endfunction

    task automatic check(input string tag, input int k, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    task automatic pop_check(input int k);
        logic [5:0] e;
        e = sb.pop_front();
        check("a_locked", k, a_lk, e[5]);
        check("a_wb_clk", k, a_wb, e[4]);
        check("a_clk_100ns", k, a_sl, e[3]);
        check("b_locked", k, b_lk, e[2]);
        check("b_wb_clk", k, b_wb, e[1]);
        check("b_clk_100ns", k, b_sl, e[0]);
    endtask

    // Drive edges k0..k0+n-1 after release, comparing 2 ns after each edge.
    task automatic run(input int k0, input int n);
        for (int k = k0; k < k0 + n; k++) begin
            sb.push_back({model(k, 64, 18, 10), model(k, 4, 5, 3)});
            @(posedge clk_in1);
            #2;
            pop_check(k);
        end
    endtask

    initial begin
        reset = 1'b0;
        // Held in reset with the clock running: everything stays low.
        for (int i = 0; i < 5; i++) begin
            sb.push_back(6'b000000);
            @(negedge clk_in1);
            pop_check(-i);
        end
        // Release between edges, then cover lock and 10,000 cycles of running.
        #1 reset = 1'b1;
        run(1, 10000);
        // Step into a high phase of wb_clk, then pulse reset for 3 ns.
        run(10001, 1);
        reset = 1'b0;
        #1;
        sb.push_back(6'b000000);
        pop_check(0);
        #2 reset = 1'b1;
        // Full lock sequence again after the short pulse.
        run(1, 300);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
